dump_tx: RTL and testbench

DUMP_TX -- requirements
Module: dump_tx

---
 rtl/dump_tx_if.sv | 33 +++
 rtl/dump_tx.sv | 132 +++++++++++++
 tb/tb_dump_tx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dump_tx_if.sv
// Byte-dump transmitter bus: the capture-stage request, the correction
// coefficients and the serial/status outputs of dump_tx.
interface dump_tx_if;
    logic        send_dump;
    logic [7:0]  dump_data;
    logic [7:0]  offset;
    logic [15:0] gain;
    logic        dump_sent;
    logic        tx;
    logic        tx_busy;

    // Capture side: requests a dump and supplies data and coefficients.
    modport master (
        output send_dump,
        output dump_data,
        output offset,
        output gain,
        input  dump_sent,
        input  tx,
        input  tx_busy
    );

    // Transmitter side.
    modport slave (
        input  send_dump,
        input  dump_data,
        input  offset,
        input  gain,
        output dump_sent,
        output tx,
        output tx_busy
    );
endinterface

// File: rtl/dump_tx.sv
// dump_tx: takes one RAM sample, applies a saturating signed offset and a
// saturating Q1.15 gain, then sends the byte as a UART 8N1 frame (LSB first).
// tx and dump_sent come from an output register stage that follows the FSM,
// so the start bit appears three edges after the accepting edge and the
// dump_sent pulse lands 3 + 10*BAUD_DIV cycles after it.
module dump_tx #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input logic      clk,
    input logic      rst_n,
    dump_tx_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        OFFS  = 3'd1,
        SCALE = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    state_t       state_q, state_d;
    logic [7:0]   data_q, data_d;
    logic [7:0]   result_q, result_d;
    logic [9:0]   frame_q, frame_d;
    logic [15:0]  baud_cnt_q, baud_cnt_d;
    logic [3:0]   bit_cnt_q, bit_cnt_d;
    logic         tx_q, tx_d;
    logic         dump_sent_q, dump_sent_d;
    logic         tx_busy_q, tx_busy_d;

    logic signed [9:0] sum;
    logic [23:0]       prod;
    logic [8:0]        scaled;

    // Datapath: signed offset sum and Q1.15 product, sampled live from the bus.
    always_comb begin
        sum    = $signed({2'b00, data_q}) + $signed({{2{bus.offset[7]}}, bus.offset});
        prod   = 24'(result_q) * 24'(bus.gain);
        scaled = prod[23:15];
    end

    // Next-state and next-output logic for the dump sequencer.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        result_d    = result_q;
        frame_d     = frame_q;
        baud_cnt_d  = baud_cnt_q;
        bit_cnt_d   = bit_cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.send_dump) begin
                    data_d  = bus.dump_data;
                    state_d = OFFS;
                end
            end
            OFFS: begin
                if (sum[9]) begin
                    result_d = 8'h00;
                end else if (sum[8]) begin
                    result_d = 8'hFF;
                end else begin
                    result_d = sum[7:0];
                end
                state_d = SCALE;
            end
            SCALE: begin
                frame_d    = {1'b1, (scaled[8] ? 8'hFF : scaled[7:0]), 1'b0};
                baud_cnt_d = 16'd0;
                bit_cnt_d  = 4'd0;
                state_d    = SHIFT;
            end
            SHIFT: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = 16'd0;
                    frame_d    = {1'b1, frame_q[9:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = DONE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Output stage: line shows the current frame LSB only while shifting.
        tx_d        = (state_q == SHIFT) ? frame_q[0] : 1'b1;
        dump_sent_d = (state_q == DONE);
        tx_busy_d   = (state_d != IDLE) || (state_q == DONE);
    end

    // State and output registers; reset aborts any frame with the line idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            data_q      <= 8'h00;
            result_q    <= 8'h00;
            frame_q     <= 10'h000;
            baud_cnt_q  <= 16'd0;
            bit_cnt_q   <= 4'd0;
            tx_q        <= 1'b1;
            dump_sent_q <= 1'b0;
            tx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            result_q    <= result_d;
            frame_q     <= frame_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            dump_sent_q <= dump_sent_d;
            tx_busy_q   <= tx_busy_d;
        end
    end

    assign bus.tx        = tx_q;
    assign bus.dump_sent = dump_sent_q;
    assign bus.tx_busy   = tx_busy_q;

endmodule

// File: tb/tb_dump_tx.sv
// Bench for dump_tx at BAUD_DIV=4: directed and random bytes, back-to-back
// requests and a reset mid-frame, each cycle checked against a reference
// timeline built from the byte transform rules.
module tb_dump_tx;

    localparam int BD  = 4;
    localparam int LAT = 3 + 10 * BD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    dump_tx_if bus ();

    dump_tx #(.BAUD_DIV(BD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference byte: saturating offset, then saturating Q1.15 gain.
    function automatic int model_byte(input logic [7:0] d, input logic [7:0] o,
                                      input logic [15:0] g);
        int s;
        int p;
        s = int'(d) + int'($signed(o));
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
        p = (s * int'(g)) / 32768;
        if (p > 255) p = 255;
        return p;
    endfunction

    // Expected line level k cycles after the accepting edge.
    function automatic logic exp_tx(input int k, input int b);
        int i;
        if (k < 3 || k >= LAT) return 1'b1;
        i = (k - 3) / BD;
        if (i == 0) return 1'b0;
        if (i == 9) return 1'b1;
        return logic'((b >> (i - 1)) & 1);
    endfunction

    task automatic chk(input string tag, input int k, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s k=%0d got=%b expected=%b", tag, k, got, exp);
        end
    endtask

    task automatic check_cycle(input int k, input int b);
        chk("tx", k, bus.tx, exp_tx(k, b));
        chk("dump_sent", k, bus.dump_sent, logic'(k == LAT));
        chk("tx_busy", k, bus.tx_busy, logic'(k >= 0 && k <= LAT));
    endtask

    // One dump: request, then per-cycle checks while coefficients are
    // disturbed outside their sampling cycles. With hold, send_dump stays high
    // until the dump_sent cycle and the next request follows one cycle later.
    task automatic run_frame(input logic [7:0] d, input logic [7:0] o,
                             input logic [15:0] g, input bit hold, input string name);
        int b;
        int nk;
        b = model_byte(d, o, g);
        $display("[TB] %s: data=%02h offset=%02h gain=%04h expect byte %02h",
                 name, d, o, g, b);
        bus.dump_data = d;
        bus.offset    = o;
        bus.gain      = g;
        bus.send_dump = 1'b1;
        nk = hold ? LAT + 2 : LAT + 3;
        for (int k = 0; k < nk; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle(k, b);
            if (k == 0) begin
                if (!hold) bus.send_dump = 1'b0;
                bus.dump_data = 8'($urandom);
            end
            if (k == 1) bus.offset = 8'($urandom);
            if (k == 2) bus.gain = 16'($urandom);
            if (hold && k == LAT) bus.send_dump = 1'b0;
        end
    endtask

    initial begin
        bus.send_dump = 1'b0;
        bus.dump_data = 8'h00;
        bus.offset    = 8'h00;
        bus.gain      = 16'h8000;

        repeat (2) @(negedge clk);
        $display("[TB] reset state");
        chk("rst_tx", -1, bus.tx, 1'b1);
        chk("rst_dump_sent", -1, bus.dump_sent, 1'b0);
        chk("rst_tx_busy", -1, bus.tx_busy, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame(8'h80, 8'h00, 16'h8000, 1'b0, "unity_0x80");
        run_frame(8'hF0, 8'h20, 16'h8000, 1'b0, "offset_sat_hi");
        run_frame(8'h10, 8'hE0, 16'h8000, 1'b0, "offset_sat_lo");
        run_frame(8'hC0, 8'h00, 16'hFFFF, 1'b0, "gain_sat");
        run_frame(8'h40, 8'h00, 16'h4000, 1'b0, "gain_half");
        run_frame(8'h5A, 8'h13, 16'h0000, 1'b0, "gain_zero");
        run_frame(8'h3C, 8'h00, 16'h8000, 1'b0, "unity_0x3c");

        for (int i = 0; i < 6; i++) begin
            run_frame(8'($urandom), 8'($urandom), 16'($urandom), 1'b0, "random");
        end

        run_frame(8'($urandom), 8'($urandom), 16'h8000, 1'b1, "b2b_first");
        run_frame(8'($urandom), 8'h00, 16'($urandom), 1'b0, "b2b_second");

        // Abort during data bit 4 of an all-zero byte, where the line is low.
        $display("[TB] reset_abort: data=00 offset=00 gain=8000, reset in data bit 4");
        bus.dump_data = 8'h00;
        bus.offset    = 8'h00;
        bus.gain      = 16'h8000;
        bus.send_dump = 1'b1;
        for (int k = 0; k <= 3 + 5 * BD + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle(k, 0);
            if (k == 0) bus.send_dump = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("abort_tx", -2, bus.tx, 1'b1);
        chk("abort_tx_busy", -2, bus.tx_busy, 1'b0);
        chk("abort_dump_sent", -2, bus.dump_sent, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 8; k++) begin
            @(negedge clk);
            chk("post_abort_tx", k, bus.tx, 1'b1);
            chk("post_abort_dump_sent", k, bus.dump_sent, 1'b0);
        end

        run_frame(8'hA5, 8'h00, 16'h8000, 1'b0, "after_reset");
        run_frame(8'($urandom), 8'($urandom), 16'($urandom), 1'b0, "random_last");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
